weight_ram_loader: RTL

- Write-side counterpart to the column-addressed weight RAM. The RAM returns one full column (NROW words) per address.
- The loader accepts a serial stream of weight words over a valid/ready handshake and packs NROW consecutive words into one column vector.
- It then issues one column write (address, data, write enable) to the RAM, for each of the NCOL columns in turn.
- It sits between the host/DMA weight stream and the weight RAM of the dot-product unit, and replaces the dummy-value preload.

---
 rtl/weight_ram_loader_pkg.sv | 31 +++
 rtl/weight_ram_loader_if.sv | 42 ++++
 rtl/weight_column_packer.sv | 54 +++++
 rtl/weight_ram_loader.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/weight_ram_loader_pkg.sv
// Shared definitions for the weight RAM loader, the weight RAM and the
// dot-product unit: matrix geometry defaults, state encoding, clog2 helper.
package weight_ram_loader_pkg;

    // Default matrix geometry shared by the weight RAM and dot-product blocks.
    localparam int DEF_NROW     = 16;
    localparam int DEF_NCOL     = 16;
    localparam int DEF_BITWIDTH = 18;

    // Loader states; the encoding is exposed on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Ceiling log2, never below 1 so a single-entry dimension still gets a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/weight_ram_loader_if.sv
// Weight stream and RAM column-write bus of the loader.
//
// Handshake: a weight word on dataIn is transferred on a rising clk edge
// exactly when dataValid && dataReady are both high in the cycle before that
// edge. The upstream must hold dataIn stable while dataValid is high and the
// word has not been transferred; dataReady never depends on dataValid.
// The write side has no back-pressure: wrAddress/wrColumn are meaningful only
// in a cycle where wrEnable is high.
interface weight_ram_loader_if
    import weight_ram_loader_pkg::*;
#(
    parameter int NROW          = DEF_NROW,
    parameter int BITWIDTH      = DEF_BITWIDTH,
    parameter int ADDR_BITWIDTH = clog2(DEF_NCOL)
);
    logic [BITWIDTH-1:0]      dataIn;
    logic                     dataValid;
    logic                     dataReady;
    logic                     wrEnable;
    logic [ADDR_BITWIDTH-1:0] wrAddress;
    logic [NROW*BITWIDTH-1:0] wrColumn;

    // Loader side: consumes the stream, drives the RAM write port.
    modport slave (
        input  dataIn,
        input  dataValid,
        output dataReady,
        output wrEnable,
        output wrAddress,
        output wrColumn
    );

    // Host side: produces the stream, observes the RAM write port.
    modport master (
        output dataIn,
        output dataValid,
        input  dataReady,
        input  wrEnable,
        input  wrAddress,
        input  wrColumn
    );
endinterface

// File: rtl/weight_column_packer.sv
// Packs NROW consecutive weight words into one column vector. Row i lands in
// bits [i*BITWIDTH +: BITWIDTH]; the row counter wraps to 0 after the last row
// so the next column starts at row 0 without an explicit clear.
module weight_column_packer
    import weight_ram_loader_pkg::*;
#(
    parameter int NROW         = DEF_NROW,
    parameter int BITWIDTH     = DEF_BITWIDTH,
    parameter int ROW_BITWIDTH = clog2(NROW)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     beat,
    input  logic [BITWIDTH-1:0]      data_in,
    output logic [NROW*BITWIDTH-1:0] column,
    output logic                     last,
    output logic [ROW_BITWIDTH-1:0]  row_cnt
);

    localparam logic [ROW_BITWIDTH-1:0] LAST_ROW = ROW_BITWIDTH'(NROW - 1);

    logic [ROW_BITWIDTH-1:0]  row_q, row_d;
    logic [NROW*BITWIDTH-1:0] column_q, column_d;

    assign last    = (row_q == LAST_ROW);
    assign column  = column_q;
    assign row_cnt = row_q;

    // Next row index and column contents: clear wins over an accepted beat.
    always_comb begin
        row_d    = row_q;
        column_d = column_q;
        if (clear) begin
            row_d    = '0;
            column_d = '0;
        end else if (beat) begin
            column_d[row_q*BITWIDTH +: BITWIDTH] = data_in;
            row_d = last ? '0 : row_q + ROW_BITWIDTH'(1);
        end
    end

    // Row counter and column register, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q    <= '0;
            column_q <= '0;
        end else begin
            row_q    <= row_d;
            column_q <= column_d;
        end
    end

endmodule

// File: rtl/weight_ram_loader.sv
// Loads a full NROW x NCOL weight matrix into the column-addressed weight RAM.
// Words arrive column-major over a valid/ready stream; every NROW words are
// packed into a column and written with a one-cycle wrEnable strobe. All
// outputs are registered so they only move on posedge and stay stable across
// the negedge at which the RAM samples them.
module weight_ram_loader
    import weight_ram_loader_pkg::*;
#(
    parameter int NROW          = DEF_NROW,
    parameter int NCOL          = DEF_NCOL,
    parameter int BITWIDTH      = DEF_BITWIDTH,
    parameter int ADDR_BITWIDTH = clog2(NCOL),
    parameter int ROW_BITWIDTH  = clog2(NROW)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output state_t                   dbg_state,
    output logic [ROW_BITWIDTH-1:0]  dbg_row_cnt,
    output logic [ADDR_BITWIDTH-1:0] dbg_col_cnt,
    weight_ram_loader_if.slave       bus
);

    localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);

    state_t                   state_q, state_d;
    logic [ADDR_BITWIDTH-1:0] col_cnt_q, col_cnt_d;
    logic                     data_ready_q, data_ready_d;
    logic                     wr_enable_q, wr_enable_d;
    logic [ADDR_BITWIDTH-1:0] wr_address_q, wr_address_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     beat;
    logic                     clear;
    logic                     last_row;
    logic [NROW*BITWIDTH-1:0] wr_column;
    logic [ROW_BITWIDTH-1:0]  row_cnt;

    // dataReady is only ever high in FILL, so it alone qualifies a beat.
    assign beat = data_ready_q & bus.dataValid;

    weight_column_packer #(
        .NROW         (NROW),
        .BITWIDTH     (BITWIDTH),
        .ROW_BITWIDTH (ROW_BITWIDTH)
    ) u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .beat    (beat),
        .data_in (bus.dataIn),
        .column  (wr_column),
        .last    (last_row),
        .row_cnt (row_cnt)
    );

    assign bus.dataReady = data_ready_q;
    assign bus.wrEnable  = wr_enable_q;
    assign bus.wrAddress = wr_address_q;
    assign bus.wrColumn  = wr_column;
    assign busy          = busy_q;
    assign done          = done_q;
    assign dbg_state     = state_q;
    assign dbg_row_cnt   = row_cnt;
    assign dbg_col_cnt   = col_cnt_q;

    // Next-state and next-output logic; each output is set for the state entered.
    always_comb begin
        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        data_ready_d = data_ready_q;
        wr_enable_d  = 1'b0;
        wr_address_d = wr_address_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        clear        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_FILL;
                    col_cnt_d    = '0;
                    data_ready_d = 1'b1;
                    busy_d       = 1'b1;
                    clear        = 1'b1;
                end
            end
            ST_FILL: begin
                if (beat && last_row) begin
                    state_d      = ST_WRITE;
                    data_ready_d = 1'b0;
                    wr_enable_d  = 1'b1;
                    wr_address_d = col_cnt_q;
                end
            end
            ST_WRITE: begin
                if (col_cnt_q == LAST_COL) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d      = ST_FILL;
                    col_cnt_d    = col_cnt_q + ADDR_BITWIDTH'(1);
                    data_ready_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                data_ready_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // FSM and registered outputs; reset aborts any load without a write or done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            col_cnt_q    <= '0;
            data_ready_q <= 1'b0;
            wr_enable_q  <= 1'b0;
            wr_address_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            data_ready_q <= data_ready_d;
            wr_enable_q  <= wr_enable_d;
            wr_address_q <= wr_address_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

endmodule
